// File: rtl/rom_loader_pkg.sv
// Shared constants, state/error encodings and address helper for the ROM boot loader.
package rom_loader_pkg;

  localparam int unsigned RV32_ADDR_WIDTH = 32;
  localparam int unsigned RV32_INST_WIDTH = 32;

  localparam logic [RV32_ADDR_WIDTH-1:0] RST_INST_ADDR = 32'h0000_0000;

  localparam logic WR_ENABLE  = 1'b1;
  localparam logic WR_DISABLE = 1'b0;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LEN   = 3'd1,
    LDR_DATA  = 3'd2,
    LDR_CHECK = 3'd3,
    LDR_DONE  = 3'd4,
    LDR_ERR   = 3'd5
  } ldr_state_e;

  typedef enum logic [1:0] {
    LDR_ERR_NONE = 2'd0,
    LDR_ERR_SIZE = 2'd1,
    LDR_ERR_SUM  = 2'd2,
    LDR_ERR_TMO  = 2'd3
  } ldr_err_e;

  // Byte address of instruction word number idx.
  function automatic logic [RV32_ADDR_WIDTH-1:0] ldr_word_addr(input logic [31:0] idx);
    return RST_INST_ADDR + RV32_ADDR_WIDTH'(idx << 2);
  endfunction

endpackage

// File: rtl/ldr_word_pack.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid_c marks the 4th byte.
module ldr_word_pack
  import rom_loader_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 byte_i,
  output logic                       word_valid_c,
  output logic [RV32_INST_WIDTH-1:0] word_c
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // Complete word is the incoming byte on top of the three buffered bytes.
  assign word_c       = {byte_i, shift_q};
  assign word_valid_c = byte_valid_i && !clr_i && (cnt_q == 2'd3);

  // Byte counter and shift buffer update; clear restarts word alignment.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
    end
  end

  // Packer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: receives a framed byte stream, writes instruction words to ROM, holds the core in reset while loading.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       rx_valid_i,
  input  logic [7:0]                 rx_data_i,
  output logic                       rx_ready_o,
  output logic                       rom_wr_en_o,
  output logic [RV32_ADDR_WIDTH-1:0] rom_wr_addr_o,
  output logic [RV32_INST_WIDTH-1:0] rom_wr_data_o,
  output logic                       core_rst_n_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 err_code_o
);

  localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      DEPTH_W32 = 32'(DEPTH_WORDS);

  ldr_state_e state_q, state_d;
  ldr_err_e   err_code_q, err_code_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic                       rx_ready_q, rx_ready_d;
  logic                       wr_en_q, wr_en_d;
  logic [RV32_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [RV32_INST_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                       core_rst_n_q, core_rst_n_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;

  logic                       xfer_c;
  logic                       pack_clr_c;
  logic                       pack_valid_c;
  logic                       word_valid_c;
  logic [RV32_INST_WIDTH-1:0] word_c;

  assign xfer_c       = rx_valid_i && rx_ready_q;
  assign pack_valid_c = xfer_c && ((state_q == LDR_LEN) || (state_q == LDR_DATA));

  ldr_word_pack u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pack_clr_c),
    .byte_valid_i (pack_valid_c),
    .byte_i       (rx_data_i),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LDR_IDLE;
      err_code_q <= LDR_ERR_NONE;
      len_q      <= 32'd0;
      idx_q      <= 32'd0;
      sum_q      <= 8'd0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      gap_q      <= gap_d;
    end
  end

  // Next-state, checksum, word index and inter-byte gap timer.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    len_d      = len_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    gap_d      = gap_q;
    pack_clr_c = 1'b0;

    case (state_q)
      LDR_IDLE, LDR_DONE, LDR_ERR: begin
        if (start_i) begin
          state_d    = LDR_LEN;
          err_code_d = LDR_ERR_NONE;
          idx_d      = 32'd0;
          sum_d      = 8'd0;
          gap_d      = '0;
          pack_clr_c = 1'b1;
        end
      end
      LDR_LEN: begin
        if (word_valid_c) begin
          len_d = word_c;
          if (word_c > DEPTH_W32) begin
            state_d    = LDR_ERR;
            err_code_d = LDR_ERR_SIZE;
          end else if (word_c == 32'd0) begin
            state_d = LDR_CHECK;
          end else begin
            state_d = LDR_DATA;
          end
        end
      end
      LDR_DATA: begin
        if (xfer_c) begin
          sum_d = sum_q + rx_data_i;
        end
        if (word_valid_c) begin
          idx_d = idx_q + 32'd1;
          if (idx_d == len_q) begin
            state_d = LDR_CHECK;
          end
        end
      end
      LDR_CHECK: begin
        if (xfer_c) begin
          if (rx_data_i == sum_q) begin
            state_d = LDR_DONE;
          end else begin
            state_d    = LDR_ERR;
            err_code_d = LDR_ERR_SUM;
          end
        end
      end
      default: begin
        state_d = LDR_IDLE;
      end
    endcase

    // Every busy-state transition needs an accepted byte, so timeout never competes with them.
    if ((state_q == LDR_LEN) || (state_q == LDR_DATA) || (state_q == LDR_CHECK)) begin
      if (xfer_c) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        gap_d      = '0;
        state_d    = LDR_ERR;
        err_code_d = LDR_ERR_TMO;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  // Output decode from the next state plus the write strobe for a completed payload word.
  always_comb begin
    rx_ready_d   = 1'b0;
    core_rst_n_d = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    wr_en_d      = WR_DISABLE;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (state_d)
      LDR_LEN, LDR_DATA, LDR_CHECK: begin
        rx_ready_d   = 1'b1;
        busy_d       = 1'b1;
        core_rst_n_d = 1'b0;
      end
      LDR_DONE: begin
        done_d = 1'b1;
      end
      LDR_ERR: begin
        err_d        = 1'b1;
        core_rst_n_d = 1'b0;
      end
      default: begin
      end
    endcase

    if ((state_q == LDR_DATA) && word_valid_c) begin
      wr_en_d   = WR_ENABLE;
      wr_addr_d = ldr_word_addr(idx_q);
      wr_data_d = word_c;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready_q   <= 1'b0;
      wr_en_q      <= WR_DISABLE;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      rx_ready_q   <= rx_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rx_ready_o    = rx_ready_q;
  assign rom_wr_en_o   = wr_en_q;
  assign rom_wr_addr_o = wr_addr_q;
  assign rom_wr_data_o = wr_data_q;
  assign core_rst_n_o  = core_rst_n_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_code_o    = err_code_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: frames driven byte by byte, ROM writes checked against a scoreboard queue.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 16;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        rom_wr_en_o;
  logic [31:0] rom_wr_addr_o;
  logic [31:0] rom_wr_data_o;
  logic        core_rst_n_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;

  int tests_run = 0;
  int tests_failed = 0;
  int n_writes = 0;
  int cyc = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          strobe_cyc[$];
  logic [31:0] wq[$];

  rom_loader #(.DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .rx_ready_o    (rx_ready_o),
    .rom_wr_en_o   (rom_wr_en_o),
    .rom_wr_addr_o (rom_wr_addr_o),
    .rom_wr_data_o (rom_wr_data_o),
    .core_rst_n_o  (core_rst_n_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rom_wr_en_o === 1'b1) begin
      n_writes++;
      strobe_cyc.push_back(cyc);
      tests_run++;
      if (exp_addr.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", rom_wr_addr_o, rom_wr_data_o);
      end else begin
        logic [31:0] ea;
        logic [31:0] ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        if (rom_wr_addr_o !== ea || rom_wr_data_o !== ed) begin
          tests_failed++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", rom_wr_addr_o, rom_wr_data_o, ea, ed);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
  endtask

  // Sends length, payload from wq and checksum XOR flip; expected writes pushed as bytes are driven.
  task automatic send_frame(input logic [7:0] flip);
    logic [7:0]  sum;
    logic [31:0] w;
    sum = 8'd0;
    send_len(32'(wq.size()));
    for (int i = 0; i < wq.size(); i++) begin
      w = wq[i];
      exp_addr.push_back(RST_INST_ADDR + 32'(i) * 32'd4);
      exp_data.push_back(w);
      for (int b = 0; b < 4; b++) begin
        sum = sum + w[8*b +: 8];
        send_byte(w[8*b +: 8]);
      end
    end
    send_byte(sum ^ flip);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({rx_ready_o, rom_wr_en_o, core_rst_n_o, busy_o, done_o, err_o, err_code_o} !== 8'b0010_0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 00100000",
               {rx_ready_o, rom_wr_en_o, core_rst_n_o, busy_o, done_o, err_o, err_code_o});
    end
    tests_run++;
    if (rom_wr_addr_o !== 32'd0 || rom_wr_data_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%h data=%h, required 0 0", rom_wr_addr_o, rom_wr_data_o);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int w0;
    w0 = n_writes;
    pulse_start();
    tests_run++;
    if ({rx_ready_o, busy_o, core_rst_n_o} !== 3'b110) begin
      tests_failed++;
      $display("FAIL basic_after_start: ready/busy/core_rst_n=%b, required 110", {rx_ready_o, busy_o, core_rst_n_o});
    end
    wq = {};
    wq.push_back(32'h0000_0013);
    wq.push_back(32'h0010_0093);
    send_frame(8'h00);
    tests_run++;
    if ({done_o, err_o, busy_o, core_rst_n_o, rx_ready_o} !== 5'b10010) begin
      tests_failed++;
      $display("FAIL basic_done: done/err/busy/core_rst_n/ready=%b, required 10010",
               {done_o, err_o, busy_o, core_rst_n_o, rx_ready_o});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (n_writes - w0 != 2 || exp_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_writes: writes=%0d pending=%0d, required 2 0", n_writes - w0, exp_addr.size());
    end
  endtask

  task automatic test_zero_len();
    int w0;
    w0 = n_writes;
    pulse_start();
    wq = {};
    send_frame(8'h00);
    tests_run++;
    if ({done_o, err_o, core_rst_n_o, err_code_o} !== 5'b10100) begin
      tests_failed++;
      $display("FAIL zero_done: done/err/core_rst_n/code=%b, required 10100", {done_o, err_o, core_rst_n_o, err_code_o});
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (n_writes != w0) begin
      tests_failed++;
      $display("FAIL zero_writes: writes=%0d, required 0", n_writes - w0);
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = n_writes;
    pulse_start();
    send_len(32'(DEPTH + 1));
    tests_run++;
    if ({err_o, done_o, busy_o, core_rst_n_o, err_code_o} !== 6'b100001) begin
      tests_failed++;
      $display("FAIL oversize: err/done/busy/core_rst_n/code=%b, required 100001",
               {err_o, done_o, busy_o, core_rst_n_o, err_code_o});
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (n_writes != w0) begin
      tests_failed++;
      $display("FAIL oversize_writes: writes=%0d, required 0", n_writes - w0);
    end
  endtask

  task automatic test_bad_checksum();
    int w0;
    w0 = n_writes;
    pulse_start();
    tests_run++;
    if (err_o !== 1'b0 || err_code_o !== 2'd0 || busy_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_clear: err=%b code=%0d busy=%b, required 0 0 1", err_o, err_code_o, busy_o);
    end
    wq = {};
    wq.push_back(32'hDEAD_BEEF);
    send_frame(8'h01);
    tests_run++;
    if ({err_o, done_o, core_rst_n_o, err_code_o} !== 5'b10010) begin
      tests_failed++;
      $display("FAIL sum_err: err/done/core_rst_n/code=%b, required 10010", {err_o, done_o, core_rst_n_o, err_code_o});
    end
    @(negedge clk);
    tests_run++;
    if (n_writes - w0 != 1) begin
      tests_failed++;
      $display("FAIL sum_writes: writes=%0d, required 1", n_writes - w0);
    end
    pulse_start();
    wq = {};
    wq.push_back(32'h0000_0013);
    send_frame(8'h00);
    tests_run++;
    if ({done_o, err_o, err_code_o, core_rst_n_o} !== 5'b10001) begin
      tests_failed++;
      $display("FAIL sum_recover: done/err/code/core_rst_n=%b, required 10001", {done_o, err_o, err_code_o, core_rst_n_o});
    end
    @(negedge clk);
    tests_run++;
    if (exp_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL sum_recover_pending: pending=%0d, required 0", exp_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = strobe_cyc.size();
    pulse_start();
    wq = {};
    for (int i = 0; i < int'(DEPTH); i++) wq.push_back($urandom);
    send_frame(8'h00);
    tests_run++;
    if (done_o !== 1'b1 || err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_depth_done: done=%b err=%b, required 1 0", done_o, err_o);
    end
    @(negedge clk);
    tests_run++;
    if (strobe_cyc.size() - s0 != int'(DEPTH)) begin
      tests_failed++;
      $display("FAIL full_depth_count: strobes=%0d, required %0d", strobe_cyc.size() - s0, DEPTH);
    end else begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        tests_run++;
        if (strobe_cyc[s0+i] - strobe_cyc[s0+i-1] != 4) begin
          tests_failed++;
          $display("FAIL strobe_spacing: gap=%0d at word %0d, required 4", strobe_cyc[s0+i] - strobe_cyc[s0+i-1], i);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int w0;
    w0 = n_writes;
    pulse_start();
    send_len(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    for (int k = 1; k <= int'(TMO); k++) begin
      @(posedge clk);
      #1;
      if (k == int'(TMO) - 1) begin
        tests_run++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL timeout_early: err=%b busy=%b after %0d cycles, required 0 1", err_o, busy_o, k);
        end
      end
    end
    tests_run++;
    if ({err_o, err_code_o, core_rst_n_o, busy_o} !== 5'b11100) begin
      tests_failed++;
      $display("FAIL timeout: err/code/core_rst_n/busy=%b, required 11100", {err_o, err_code_o, core_rst_n_o, busy_o});
    end
    tests_run++;
    if (n_writes != w0) begin
      tests_failed++;
      $display("FAIL timeout_writes: writes=%0d, required 0", n_writes - w0);
    end
  endtask

  task automatic test_start_ignored_and_reset();
    int w0;
    pulse_start();
    send_len(32'd4);
    exp_addr.push_back(RST_INST_ADDR);
    exp_data.push_back(32'hA1B2_C3D4);
    send_byte(8'hD4); send_byte(8'hC3); send_byte(8'hB2); send_byte(8'hA1);
    exp_addr.push_back(RST_INST_ADDR + 32'd4);
    exp_data.push_back(32'h5566_7788);
    send_byte(8'h88); send_byte(8'h77);
    pulse_start();
    tests_run++;
    if (busy_o !== 1'b1 || rx_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_ignored_busy: busy=%b ready=%b, required 1 1", busy_o, rx_ready_o);
    end
    send_byte(8'h66); send_byte(8'h55);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_addr.size() != 0) begin
      tests_failed++;
      $display("FAIL start_ignored_write: pending=%0d, required 0", exp_addr.size());
    end
    send_byte(8'h01); send_byte(8'h02);
    w0 = n_writes;
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h03;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rx_ready_o, rom_wr_en_o, core_rst_n_o, busy_o, done_o, err_o, err_code_o} !== 8'b0010_0000
        || rom_wr_addr_o !== 32'd0 || rom_wr_data_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset: flags=%b addr=%h data=%h, required 00100000 0 0",
               {rx_ready_o, rom_wr_en_o, core_rst_n_o, busy_o, done_o, err_o, err_code_o}, rom_wr_addr_o, rom_wr_data_o);
    end
    rx_data_i = 8'h04;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data_i = 8'(8'h10 + i);
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (n_writes != w0 || busy_o !== 1'b0 || core_rst_n_o !== 1'b1 || rx_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: writes=%0d busy=%b core_rst_n=%b ready=%b, required 0 0 1 0",
               n_writes - w0, busy_o, core_rst_n_o, rx_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_oversize();
    test_bad_checksum();
    test_back_to_back();
    test_timeout();
    test_start_ignored_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time controller that sequences the instruction ROM's write port. It receives a framed byte stream through a valid/ready interface, assembles little-endian 32-bit instruction words, and writes them to consecutive ROM addresses starting at `RST_INST_ADDR`. It holds the RISC-V core in reset while a load is in progress. The block sits in riscv_soc between a byte source (UART RX or testbench) and the ROM write port, which is otherwise tied to `WR_DISABLE`.

## Interface
Parameters:
- DEPTH_WORDS, default 4096: ROM capacity in words; the largest length the loader accepts.
- TIMEOUT_CYCLES, default 1000000: maximum gap, in clk cycles, between accepted bytes mid-frame.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_valid_i  in  1  byte available.
- rx_data_i  in  8  byte value.
- rx_ready_o  out  1  loader accepts a byte; a transfer occurs when valid and ready are both high.
- rom_wr_en_o  out  1  ROM write strobe (`WR_ENABLE`/`WR_DISABLE`).
- rom_wr_addr_o  out  `RV32_ADDR_WIDTH`  byte address of the write.
- rom_wr_data_o  out  `RV32_INST_WIDTH`  instruction word.
- core_rst_n_o  out  1  active-low reset to riscv_core, ANDed with rst_n at the SoC level.
- busy_o  out  1  high in LEN, DATA or CHECK.
- done_o  out  1  high in DONE.
- err_o  out  1  high in ERROR.
- err_code_o  out  2  error cause: 0 none, 1 oversize, 2 checksum, 3 timeout.

## Operation
- Frame format:
  - 4 length bytes, LSB first, giving N words.
  - N×4 payload bytes, with each word LSB first.
  - 1 checksum byte equal to the sum of all payload bytes mod 256. Length bytes are excluded from the sum.
- States and transitions:
  - IDLE: start_i → LEN.
  - LEN: fourth byte accepted → DATA, or → CHECK if N==0, or → ERROR(1) if N>DEPTH_WORDS. No write occurs on the oversize path.
  - DATA: after the 4th byte of the last word → CHECK.
  - CHECK: on the checksum byte, a match goes to DONE and a mismatch goes to ERROR(2).
  - DONE and ERROR: start_i → LEN. On this restart the word index, checksum accumulator and err_code_o clear.
- Timeout: in LEN, DATA or CHECK, a gap counter counts cycles since the last accepted byte (or since start_i). When the count reaches TIMEOUT_CYCLES → ERROR(3).
- start_i received in LEN, DATA or CHECK is ignored.
- Write address: `RST_INST_ADDR` + 4×word_index. The word index is 32 bits wide and never wraps, because N≤DEPTH_WORDS.
- Writes already completed before an error are not rolled back.
- core_rst_n_o is low in LEN, DATA, CHECK and ERROR, and high in IDLE and DONE. The core therefore runs the existing ROM contents after power-up and restarts from `RST_INST_ADDR` on DONE.

## Timing
- Reset values:
  - state IDLE.
  - rx_ready_o=0, rom_wr_en_o=0, rom_wr_addr_o=0, rom_wr_data_o=0.
  - core_rst_n_o=1, busy_o=0, done_o=0, err_o=0, err_code_o=0.
- All outputs are registered.
- rx_ready_o rises in the cycle after start_i and is high throughout LEN, DATA and CHECK. The loader never stalls the source.
- Write strobe: rom_wr_en_o is high for exactly one cycle, the cycle after the 4th byte of a word is accepted. Address and data are valid in that same cycle. A new byte may be accepted during the write cycle.
- Maximum rate is 1 byte/cycle, so back-to-back words produce a strobe every 4 cycles.
- The state change to DONE or ERROR, and the matching core_rst_n_o, done_o and err_o values, become visible the cycle after the deciding byte or timeout.
- Asserting rst_n low mid-load immediately returns the block to its reset values. No further writes occur.

## Structure
- Add to defines.v:
  - state encodings LDR_IDLE, LDR_LEN, LDR_DATA, LDR_CHECK, LDR_DONE, LDR_ERR.
  - error codes LDR_ERR_NONE, LDR_ERR_SIZE, LDR_ERR_SUM, LDR_ERR_TMO.
- Reuse the existing `WR_ENABLE`, `WR_DISABLE` and `RST_INST_ADDR` defines.
- One sub-module: ldr_word_pack (byte counter plus 32-bit shift assembler producing a word_valid pulse). The FSM, checksum and timeout logic stay in rom_loader.

## Test plan
- Load N=2 with words 0x00000013 and 0x00100093, checksum 0xB6: writes go to addresses `RST_INST_ADDR` and `RST_INST_ADDR`+4 with those values; the block reaches DONE and core_rst_n_o returns to 1.
- Load N=0 with checksum 0x00: the block reaches DONE with no write strobe.
- Length DEPTH_WORDS+1: ERROR with err_code_o=1, zero writes, core_rst_n_o=0.
- Load N=1 with a wrong checksum: one write, then ERROR with err_code_o=2; a following start_i plus a valid frame reaches DONE.
- Stop rx_valid_i after 3 payload bytes, with TIMEOUT_CYCLES set to 16: ERROR with err_code_o=3 exactly 16 cycles after the last accepted byte.
- Pulse start_i mid-DATA, then deassert rst_n mid-DATA: the start_i is ignored; on reset all outputs take their reset values the same cycle and no further write strobes occur.
